// File: rtl/serial_tx_scheduler_if.sv
// Requester, baud and serial-line bundle for the two-source transmit scheduler.
// master drives requests and the baud tick; slave is the scheduler itself.
interface serial_tx_scheduler_if #(
    parameter int DATA_BITS = 8
);

    logic                 BaudTick;
    logic                 Req0;
    logic [DATA_BITS-1:0] Data0;
    logic                 Ack0;
    logic                 Req1;
    logic [DATA_BITS-1:0] Data1;
    logic                 Ack1;
    logic                 TxOut;
    logic                 Busy;
    logic                 ActiveSrc;

    modport master (
        output BaudTick,
        output Req0,
        output Data0,
        output Req1,
        output Data1,
        input  Ack0,
        input  Ack1,
        input  TxOut,
        input  Busy,
        input  ActiveSrc
    );

    modport slave (
        input  BaudTick,
        input  Req0,
        input  Data0,
        input  Req1,
        input  Data1,
        output Ack0,
        output Ack1,
        output TxOut,
        output Busy,
        output ActiveSrc
    );

endinterface

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler for two byte sources feeding one 8N1 serial line.
// Bit timing is taken from the external BaudTick pulse.
module serial_tx_scheduler #(
    parameter int DATA_BITS = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    serial_tx_scheduler_if.slave  bus
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_cnt;
    logic                 r_tx;
    logic                 r_ack0;
    logic                 r_ack1;
    logic                 r_last_grant;
    logic                 r_active_src;

    logic                 w_tick;
    logic                 w_any_req;
    logic                 w_pick1;
    logic                 w_capture;
    logic [2:0]           w_state_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_tx_nxt;

    assign w_tick    = bus.BaudTick;
    assign w_any_req = bus.Req0 | bus.Req1;

    // On a tie the requester that did not win last time goes first.
    assign w_pick1 = bus.Req1 & (~bus.Req0 | ~r_last_grant);

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = r_tx;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_any_req) begin
                    w_capture   = 1'b1;
                    w_shift_nxt = w_pick1 ? bus.Data1 : bus.Data0;
                    w_state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                if (w_tick) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_cnt == LAST_BIT) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Acks land in the SYNC cycle, so a still-high Req cannot be taken twice.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_last_grant <= 1'b1;
            r_active_src <= 1'b0;
        end else begin
            r_ack0 <= w_capture & ~w_pick1;
            r_ack1 <= w_capture &  w_pick1;
            if (w_capture) begin
                r_last_grant <= w_pick1;
                r_active_src <= w_pick1;
            end
        end
    end

    assign bus.TxOut     = r_tx;
    assign bus.Ack0      = r_ack0;
    assign bus.Ack1      = r_ack1;
    assign bus.Busy      = (r_state != S_IDLE);
    assign bus.ActiveSrc = r_active_src;

endmodule
